// File: rtl/tff_counter_if.sv
// tff_counter_if: control/data bundle between a tff_counter and its driver
interface tff_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] t;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    modport master (output en, mode, t, up, load, d, input q, tc);
    modport slave  (input en, mode, t, up, load, d, output q, tc);
endinterface

// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit toggle bank or wrap/saturate up/down counter with load and terminal count
module tff_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input logic          clk,
    input logic          rst,
    tff_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam bit SAT = SATURATE != 0;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    // next state: load beats stepping; tc only marks a boundary step taken on this edge
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (bus.load) begin
            q_d = (bus.mode && bus.d > MAX) ? MAX : bus.d;
        end else if (bus.en && !bus.mode) begin
            q_d = q_q ^ bus.t;
        end else if (bus.en && bus.up) begin
            tc_d = q_q >= MAX;
            q_d  = !tc_d ? q_q + 1'b1 : SAT ? MAX : '0;
        end else if (bus.en) begin
            tc_d = q_q == '0;
            q_d  = tc_d ? (SAT ? '0 : MAX) : q_q > MAX ? MAX : q_q - 1'b1;
        end
    end
    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end
    assign bus.q  = q_q;
    assign bus.tc = tc_q;
endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: directed checks of wrap and saturate instances against a spec-level model
module tb_tff_counter;
    logic       clk = 1'b0;
    logic       rst, en, mode, up, load;
    logic [3:0] t, d;
    int         checks = 0;
    int         passed = 0;
    int         mq[2];
    int         mtc[2];

    tff_counter_if #(.WIDTH(4)) b0 ();
    tff_counter_if #(.WIDTH(4)) b1 ();

    assign b0.en = en;     assign b1.en = en;
    assign b0.mode = mode; assign b1.mode = mode;
    assign b0.t = t;       assign b1.t = t;
    assign b0.up = up;     assign b1.up = up;
    assign b0.load = load; assign b1.load = load;
    assign b0.d = d;       assign b1.d = d;

    tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic m,
                         input logic u, input logic [3:0] tv, input logic [3:0] dv);
        rst = r; load = l; en = e; mode = m; up = u; t = tv; d = dv;
    endtask

    // advance the model by the rules for the applied inputs, clock once, compare both instances
    task automatic step();
        int nq, nt;
        for (int k = 0; k < 2; k++) begin
            nq = mq[k];
            nt = 0;
            if (rst) nq = 0;
            else if (load) nq = (mode && int'(d) > 9) ? 9 : int'(d);
            else if (en && !mode) nq = mq[k] ^ int'(t);
            else if (en && up) begin
                if (mq[k] >= 9) begin nq = (k == 1) ? 9 : 0; nt = 1; end
                else nq = mq[k] + 1;
            end else if (en) begin
                if (mq[k] == 0) begin nq = (k == 1) ? 0 : 9; nt = 1; end
                else if (mq[k] > 9) nq = 9;
                else nq = mq[k] - 1;
            end
            mq[k]  = nq;
            mtc[k] = nt;
        end
        @(posedge clk);
        #1;
        chk("q_wrap", int'(b0.q), mq[0]);
        chk("tc_wrap", int'(b0.tc), mtc[0]);
        chk("q_sat", int'(b1.q), mq[1]);
        chk("tc_sat", int'(b1.tc), mtc[1]);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("lit_reset_q", int'(b0.q), 0);
        // preload 0xA in toggle mode, then reset must dominate load and en
        drive(0, 1, 0, 0, 0, 0, 4'hA);
        step();
        chk("lit_preload", int'(b0.q), 10);
        drive(1, 1, 1, 1, 1, 0, 4'h5);
        step();
        chk("lit_rst_dom_q", int'(b0.q), 0);
        chk("lit_rst_dom_tc", int'(b0.tc), 0);
        // toggle bank
        drive(0, 0, 1, 0, 0, 4'b0101, 0);
        step();
        chk("lit_tog1", int'(b0.q), 5);
        step();
        chk("lit_tog2", int'(b0.q), 0);
        drive(0, 0, 1, 0, 0, 4'b0000, 0);
        step();
        chk("lit_tog_hold", int'(b0.q), 0);
        // count up 10 edges from 0
        drive(0, 0, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("lit_up_q", int'(b0.q), i % 10);
            chk("lit_up_tc", int'(b0.tc), (i == 10) ? 1 : 0);
        end
        chk("lit_sat_top", int'(b1.q), 9);
        // wrap down from 0
        drive(0, 0, 1, 1, 0, 0, 0);
        step();
        chk("lit_down_wrap_q", int'(b0.q), 9);
        chk("lit_down_wrap_tc", int'(b0.tc), 1);
        // saturate up from 8
        drive(0, 1, 0, 1, 0, 0, 4'd8);
        step();
        drive(0, 0, 1, 1, 1, 0, 0);
        step();
        chk("lit_sat_q1", int'(b1.q), 9);
        chk("lit_sat_tc1", int'(b1.tc), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lit_sat_q", int'(b1.q), 9);
            chk("lit_sat_tc", int'(b1.tc), 1);
        end
        // saturate down at 0
        drive(0, 1, 0, 1, 0, 0, 4'd0);
        step();
        drive(0, 0, 1, 1, 0, 0, 0);
        step();
        chk("lit_sat_dn_q", int'(b1.q), 0);
        chk("lit_sat_dn_tc", int'(b1.tc), 1);
        // load clamp, unclamped toggle-mode load, reinterpretation in counter mode
        drive(0, 1, 0, 1, 0, 0, 4'hF);
        step();
        chk("lit_load_clamp", int'(b0.q), 9);
        drive(0, 1, 0, 0, 0, 0, 4'hF);
        step();
        chk("lit_load_raw", int'(b0.q), 15);
        drive(0, 0, 1, 1, 0, 0, 0);
        step();
        chk("lit_over_q", int'(b0.q), 9);
        chk("lit_over_tc", int'(b0.tc), 0);
        step();
        chk("lit_over_next", int'(b0.q), 8);
        // hold with random don't-care inputs
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1'($urandom), 4'($urandom), 4'($urandom));
            step();
            chk("lit_hold_q", int'(b0.q), 8);
            chk("lit_hold_tc", int'(b0.tc), 0);
        end
        // load beats the boundary step
        drive(0, 1, 0, 1, 1, 0, 4'd9);
        step();
        drive(0, 1, 1, 1, 1, 0, 4'd3);
        step();
        chk("lit_load_prio_q", int'(b0.q), 3);
        chk("lit_load_prio_tc", int'(b0.tc), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
